counter_arb: RTL
================

COUNTER_ARB -- requirements
Module: counter_arb

Interface
REQ-001 The block SHALL have parameter SIZE, default 10, giving the width of every counter, increment and sum.
REQ-002 The block SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 The block SHALL have port clr, input, 1, synchronous clear of both counters.
REQ-005 The block SHALL have port req, input, 2, per-requester update request; bit i belongs to requester i.
REQ-006 The block SHALL have port inc0, input, SIZE, increment amount for requester 0.
REQ-007 The block SHALL have port inc1, input, SIZE, increment amount for requester 1.
REQ-008 The block SHALL have port ack, output, 2, one-hot completion pulse per requester.
REQ-009 The block SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have ports cnt0 and cnt1, output, SIZE each, the counter registers.
REQ-011 The block SHALL have port sum, output, SIZE, combinational cnt0 + cnt1.

Function
REQ-012 The block SHALL contain exactly one SIZE-bit adder, shared between both counter updates; the sum output uses a separate adder.
REQ-013 The FSM SHALL have the states IDLE, ADD and ACK; busy = (state != IDLE); ack is a Moore output of ACK only.
- IDLE: when req != 0 at a clock edge, the block selects a winner, latches the winner index and its inc value, and moves to ADD.
- IDLE: when req == 0, the block stays in IDLE.
- ADD: at the next edge, cnt[idx] <= cnt[idx] + inc_latched and the state moves to ACK.
- ACK: ack[idx] = 1 for exactly one cycle; at the next edge the priority pointer toggles and the state returns to IDLE.
REQ-014 Arbitration SHALL be round-robin with a 1-bit pointer (reset value 0) naming the preferred requester.
- When one req bit is set, that requester wins.
- When both are set, the pointer's requester wins.
- The pointer toggles to the other requester after every completed transaction.
REQ-015 Latency SHALL be fixed: req sampled at edge E0 -> counter updated at E1 -> ack high from E1 to E2 -> IDLE after E2; throughput is one transaction per 3 cycles.
REQ-016 A requester SHALL hold req until it sees its ack; req or inc changes after E0 do not affect the in-flight transaction, which completes normally.
REQ-017 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-018 Without the configuration macro, counter updates and sum SHALL wrap modulo 2^SIZE.
REQ-019 clr SHALL zero cnt0 and cnt1 at the edge where it is sampled high, with priority over a same-edge ADD write; FSM, pointer and ack sequencing are unaffected, so the ack is still issued.
REQ-020 An inc value of 0 SHALL complete a normal transaction that leaves the counter unchanged.

Reset
REQ-021 While rst is high, the block SHALL asynchronously force: state = IDLE, pointer = 0, cnt0 = cnt1 = 0, latched index and increment = 0.
REQ-022 As a consequence of REQ-021, ack = 00, busy = 0 and sum = 0 while rst is high.
REQ-023 rst asserted in ADD or ACK SHALL abort the transaction: no counter write, no ack pulse.
REQ-024 After rst deasserts, the first sampled req SHALL start a fresh transaction.

Configuration
REQ-025 When COUNTER_ARB_SAT_EN is defined, each counter update SHALL saturate at 2^SIZE-1 instead of wrapping.
REQ-026 When COUNTER_ARB_SAT_EN is defined, sum SHALL also saturate at 2^SIZE-1.
REQ-027 When COUNTER_ARB_SAT_EN is undefined, both counter updates and sum SHALL wrap (REQ-018); the port list is identical in both builds.

Verification
REQ-028 Scenario single: SIZE=10, req=01, inc0=5 -> ack=01 two cycles after sampling; cnt0=5, cnt1=0, sum=5.
REQ-029 Scenario contention: req=11 held, inc0=1, inc1=2, pointer=0 -> acks occur in order 01, 10, 01, 10, one every 3 cycles; after four acks cnt0=2, cnt1=4.
REQ-030 Scenario wrap (macro undefined): cnt0=1020, inc0=10 -> cnt0=6; with cnt1=1020, sum=2.
REQ-031 Scenario saturate (COUNTER_ARB_SAT_EN defined): cnt0=1020, inc0=10 -> cnt0=1023; with cnt1=1023, sum=1023.
REQ-032 Scenario clr collision: clr high at the ADD edge of a req=10, inc1=7 transaction -> cnt1=0 and ack=10 still pulses.
REQ-033 Scenario reset mid-operation: rst pulsed while in ADD -> ack never pulses, cnt0=cnt1=0, busy=0; the next req=10 wins and completes.

Source files
------------

// File: rtl/counter_arb.sv
// -----------------------------------------------------------------------------
// counter_arb
// Two SIZE-bit counters updated through one shared adder. Two requesters take
// turns through a round-robin arbiter. Each transaction takes three cycles:
// IDLE samples req -> ADD writes the counter -> ACK pulses ack for one cycle.
//
// Configuration macro: COUNTER_ARB_SAT_EN
//   undefined : counter updates and sum wrap modulo 2^SIZE
//   defined   : counter updates and sum saturate at 2^SIZE-1
//   The port list is the same in both builds.
//
// Ports
//   clk   in   1     clock, rising edge
//   rst   in   1     asynchronous active-high reset
//   clr   in   1     synchronous clear of both counters (wins over an ADD write)
//   req   in   2     update request, bit i = requester i
//   inc0  in   SIZE  increment for requester 0
//   inc1  in   SIZE  increment for requester 1
//   ack   out  2     one-hot completion pulse (high in ACK only)
//   busy  out  1     high whenever the FSM is not in IDLE
//   cnt0  out  SIZE  counter 0
//   cnt1  out  SIZE  counter 1
//   sum   out  SIZE  cnt0 + cnt1 (combinational, separate adder)
// -----------------------------------------------------------------------------
module counter_arb #(
  parameter int SIZE = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic [1:0]      req,
  input  logic [SIZE-1:0] inc0,
  input  logic [SIZE-1:0] inc1,
  output logic [1:0]      ack,
  output logic            busy,
  output logic [SIZE-1:0] cnt0,
  output logic [SIZE-1:0] cnt1,
  output logic [SIZE-1:0] sum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                 state_reg;
  logic                   ptr_reg;     // preferred requester on contention
  logic                   idx_reg;     // requester of the in-flight transaction
  logic [SIZE-1:0]        inc_reg;     // increment latched at the request edge
  logic [1:0]             ack_reg;
  logic                   busy_reg;
  logic [1:0][SIZE-1:0]   cnt_reg;
  logic [1:0][SIZE-1:0]   cnt_next;

  logic                   win_next;
  logic [SIZE-1:0]        add_a;
  logic [SIZE-1:0]        add_result;

  // Round-robin winner: a lone requester always wins, a tie goes to ptr_reg.
  always_comb begin
    win_next = ptr_reg;
    case (req)
      2'b01:   win_next = 1'b0;
      2'b10:   win_next = 1'b1;
      default: win_next = ptr_reg;
    endcase
  end

  // The single shared update adder: operand A is muxed by the latched index.
  assign add_a = idx_reg ? cnt_reg[1] : cnt_reg[0];

`ifdef COUNTER_ARB_SAT_EN
  logic [SIZE:0] add_full;
  logic [SIZE:0] sum_full;

  assign add_full   = {1'b0, add_a} + {1'b0, inc_reg};
  assign add_result = add_full[SIZE] ? {SIZE{1'b1}} : add_full[SIZE-1:0];

  assign sum_full   = {1'b0, cnt_reg[0]} + {1'b0, cnt_reg[1]};
  assign sum        = sum_full[SIZE] ? {SIZE{1'b1}} : sum_full[SIZE-1:0];
`else
  assign add_result = add_a + inc_reg;
  assign sum        = cnt_reg[0] + cnt_reg[1];
`endif

  // Next value for each counter. clr has priority over the ADD-state write.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      always_comb begin
        cnt_next[gi] = cnt_reg[gi];
        if (clr)
          cnt_next[gi] = '0;
        else if (state_reg == ADD && idx_reg == 1'(gi))
          cnt_next[gi] = add_result;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      idx_reg   <= 1'b0;
      inc_reg   <= '0;
      ack_reg   <= 2'b00;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      cnt_reg <= cnt_next;
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            idx_reg   <= win_next;
            inc_reg   <= win_next ? inc1 : inc0;
            busy_reg  <= 1'b1;
            state_reg <= ADD;
          end
        end
        ADD: begin
          // ack is registered so it is high for exactly the ACK cycle.
          ack_reg   <= idx_reg ? 2'b10 : 2'b01;
          state_reg <= ACK;
        end
        ACK: begin
          ack_reg   <= 2'b00;
          busy_reg  <= 1'b0;
          ptr_reg   <= ~ptr_reg;
          state_reg <= IDLE;
        end
        default: begin
          ack_reg   <= 2'b00;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ack  = ack_reg;
  assign busy = busy_reg;
  assign cnt0 = cnt_reg[0];
  assign cnt1 = cnt_reg[1];

endmodule
